// File: rtl/tt_um_jimktrains_vslc_servo_ramp.sv
// rtl/tt_um_jimktrains_vslc_servo_ramp.sv - frame-paced servo pulse-width ramp generator
// Steps the commanded width toward a target once per frame, with a one-entry target queue.
module tt_um_jimktrains_vslc_servo_ramp #(
  parameter logic [15:0] INIT_POS = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ramp_enabled,
  input  logic [15:0] frame_len,
  input  logic [7:0]  step_val,
  input  logic        tgt_valid,
  input  logic [15:0] tgt_val,
  output logic        tgt_ready,
  output logic [15:0] servo_set_val,
  output logic        frame_tick,
  output logic        at_target
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [15:0] tgt;
  logic [15:0] pend;
  logic        pend_full;
  logic        wrap;
  logic        accept;
  logic [15:0] stepped;
  logic [15:0] tgt_nx;
  logic [16:0] pos_x, tgt_x, step_x, up_sum, dn_lim;

  assign tgt_ready = rst_n & ramp_enabled & ~pend_full;
  assign accept    = tgt_valid & tgt_ready;
  // >= rather than == so shrinking frame_len below the count wraps immediately
  assign wrap      = ramp_enabled & (cnt >= frame_len);
  assign at_target = (state == IDLE);

  always_comb begin
    pos_x   = {1'b0, servo_set_val};
    tgt_x   = {1'b0, tgt};
    step_x  = {9'd0, step_val};
    up_sum  = pos_x + step_x;
    dn_lim  = tgt_x + step_x;
    stepped = servo_set_val;
    if (servo_set_val < tgt) begin
      if (step_val == 8'd0 || up_sum >= tgt_x) stepped = tgt;
      else stepped = up_sum[15:0];
    end else if (servo_set_val > tgt) begin
      if (step_val == 8'd0 || dn_lim >= pos_x) stepped = tgt;
      else stepped = servo_set_val - {8'd0, step_val};
    end
  end

  always_comb begin
    tgt_nx   = pend_full ? pend : tgt;
    state_nx = state;
    if (wrap) state_nx = (stepped == tgt_nx) ? IDLE : RAMP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 16'd0;
      frame_tick    <= 1'b0;
      servo_set_val <= INIT_POS;
      tgt           <= INIT_POS;
      pend          <= 16'd0;
      pend_full     <= 1'b0;
    end else begin
      if (!ramp_enabled) begin
        cnt        <= 16'd0;
        frame_tick <= 1'b0;
      end else if (wrap) begin
        cnt           <= 16'd0;
        frame_tick    <= 1'b1;
        servo_set_val <= stepped;
        tgt           <= tgt_nx;
        pend_full     <= 1'b0;
      end else begin
        cnt        <= cnt + 16'd1;
        frame_tick <= 1'b0;
      end
      // Acceptance after the transfer so a tick-edge arrival waits for the next frame
      if (accept) begin
        pend      <= tgt_val;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_servo_ramp.sv
// tb/tb_tt_um_jimktrains_vslc_servo_ramp.sv - directed bench for the servo ramp generator
module tb_tt_um_jimktrains_vslc_servo_ramp;

  logic        clk;
  logic        rst_n;
  logic        ramp_enabled;
  logic [15:0] frame_len;
  logic [7:0]  step_val;
  logic        tgt_valid;
  logic [15:0] tgt_val;
  logic        tgt_ready;
  logic [15:0] servo_set_val;
  logic        frame_tick;
  logic        at_target;

  int checks = 0;
  int errors = 0;
  int n;
  int ticks;

  tt_um_jimktrains_vslc_servo_ramp #(.INIT_POS(16'd0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ramp_enabled(ramp_enabled),
    .frame_len(frame_len),
    .step_val(step_val),
    .tgt_valid(tgt_valid),
    .tgt_val(tgt_val),
    .tgt_ready(tgt_ready),
    .servo_set_val(servo_set_val),
    .frame_tick(frame_tick),
    .at_target(at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic cycles_to_tick(output int cnt_out);
    cnt_out = 0;
    do begin
      step_clk(1);
      cnt_out++;
    end while (!frame_tick && cnt_out < 200);
  endtask

  task automatic wait_tick(input string tag);
    int k;
    cycles_to_tick(k);
    chk({tag, "_tick"}, {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic offer(input logic [15:0] v);
    tgt_valid = 1'b1;
    tgt_val   = v;
    step_clk(1);
    tgt_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    ramp_enabled = 1'b1;
    frame_len    = 16'd9;
    step_val     = 8'd100;
    tgt_valid    = 1'b0;
    tgt_val      = 16'd0;
    step_clk(2);
    chk("rst_pos", servo_set_val, 32'd0);
    chk("rst_at_target", at_target, 32'd1);
    chk("rst_tick", frame_tick, 32'd0);
    chk("rst_ready", tgt_ready, 32'd0);

    // Frame timing with frame_len = 9
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", tgt_ready, 32'd1);
    cycles_to_tick(n);
    chk("first_tick_cycles", n, 32'd10);
    step_clk(1);
    chk("tick_one_cycle", frame_tick, 32'd0);
    cycles_to_tick(n);
    chk("tick_period", n, 32'd9);
    step_clk(7);
    chk("no_tick_cnt7", frame_tick, 32'd0);
    frame_len = 16'd3;
    step_clk(1);
    chk("shrink_frame_tick", frame_tick, 32'd1);

    // Ramp 0 -> 350 in steps of 100
    offer(16'd350);
    chk("pend_full_ready", tgt_ready, 32'd0);
    wait_tick("r0");
    chk("ramp_pos0", servo_set_val, 32'd0);
    chk("ramp_at0", at_target, 32'd0);
    chk("ready_after_xfer", tgt_ready, 32'd1);
    wait_tick("r1");
    chk("ramp_pos100", servo_set_val, 32'd100);
    step_clk(2);
    chk("mid_frame_hold", servo_set_val, 32'd100);
    wait_tick("r2");
    chk("ramp_pos200", servo_set_val, 32'd200);
    wait_tick("r3");
    chk("ramp_pos300", servo_set_val, 32'd300);
    chk("ramp_at300", at_target, 32'd0);
    wait_tick("r4");
    chk("ramp_pos350", servo_set_val, 32'd350);
    chk("ramp_at350", at_target, 32'd1);

    // Pending slot and tick-edge acceptance
    offer(16'd500);
    tgt_valid = 1'b1;
    tgt_val   = 16'd600;
    #1;
    chk("second_valid_blocked", tgt_ready, 32'd0);
    tgt_valid = 1'b0;
    wait_tick("p0");
    chk("p_pos350", servo_set_val, 32'd350);
    chk("p_at0", at_target, 32'd0);
    step_clk(3);
    tgt_valid = 1'b1;
    tgt_val   = 16'd600;
    step_clk(1);
    tgt_valid = 1'b0;
    chk("p_tick_edge", frame_tick, 32'd1);
    chk("p_pos450", servo_set_val, 32'd450);
    chk("p_ready_full", tgt_ready, 32'd0);
    wait_tick("p1");
    chk("p_pos500", servo_set_val, 32'd500);
    chk("p_at500", at_target, 32'd0);
    wait_tick("p2");
    chk("p_pos600", servo_set_val, 32'd600);
    chk("p_at600", at_target, 32'd1);

    // Disable mid-ramp
    offer(16'd1000);
    wait_tick("d0");
    wait_tick("d1");
    chk("d_pos700", servo_set_val, 32'd700);
    step_clk(1);
    ramp_enabled = 1'b0;
    #1;
    chk("d_ready_low", tgt_ready, 32'd0);
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      step_clk(1);
      if (frame_tick) ticks++;
    end
    chk("d_no_ticks", ticks, 32'd0);
    chk("d_pos_frozen", servo_set_val, 32'd700);
    ramp_enabled = 1'b1;
    cycles_to_tick(n);
    chk("d_reenable_cycles", n, 32'd4);
    chk("d_pos800", servo_set_val, 32'd800);

    // Jump with step 0, then ramp down without underflow
    step_val = 8'd0;
    offer(16'd40);
    wait_tick("j0");
    chk("j_pos1000", servo_set_val, 32'd1000);
    step_val = 8'd255;
    wait_tick("j1");
    chk("dn_745", servo_set_val, 32'd745);
    wait_tick("j2");
    chk("dn_490", servo_set_val, 32'd490);
    wait_tick("j3");
    chk("dn_235", servo_set_val, 32'd235);
    wait_tick("j4");
    chk("dn_40", servo_set_val, 32'd40);
    chk("dn_at40", at_target, 32'd1);

    // Ramp up against the top of the range
    step_val = 8'd0;
    offer(16'hFFF0);
    wait_tick("h0");
    offer(16'hFFFF);
    wait_tick("h1");
    chk("h_posfff0", servo_set_val, 32'hFFF0);
    step_val = 8'd200;
    wait_tick("h2");
    chk("h_posffff", servo_set_val, 32'hFFFF);
    chk("h_atffff", at_target, 32'd1);

    // frame_len = 0 ticks every cycle
    frame_len = 16'd0;
    step_clk(1);
    chk("fl0_tick_a", frame_tick, 32'd1);
    step_clk(1);
    chk("fl0_tick_b", frame_tick, 32'd1);
    step_clk(1);
    chk("fl0_tick_c", frame_tick, 32'd1);

    // Asynchronous reset mid-ramp
    frame_len = 16'd3;
    step_val  = 8'd10;
    offer(16'd0);
    wait_tick("a0");
    wait_tick("a1");
    chk("a_posfff5", servo_set_val, 32'hFFF5);
    offer(16'd7);
    #3;
    rst_n = 1'b0;
    #1;
    chk("a_rst_pos", servo_set_val, 32'd0);
    chk("a_rst_at", at_target, 32'd1);
    chk("a_rst_tick", frame_tick, 32'd0);
    chk("a_rst_ready", tgt_ready, 32'd0);
    step_clk(1);
    rst_n = 1'b1;
    wait_tick("a2");
    chk("a_after_pos", servo_set_val, 32'd0);
    chk("a_after_at", at_target, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_jimktrains_vslc_servo_ramp.md
TT_UM_JIMKTRAINS_VSLC_SERVO_RAMP -- requirements
Module: tt_um_jimktrains_vslc_servo_ramp

Interface
REQ-001 Parameter INIT_POS, default 16'd0: servo_set_val and target value after reset.
REQ-002 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port ramp_enabled  input  1  high = frame counting and ramping active.
REQ-005 Port frame_len  input  16  frame period minus one, in clk cycles.
REQ-006 Port step_val  input  8  maximum width change per frame; 0 = jump directly to target.
REQ-007 Port tgt_valid  input  1  new target offered.
REQ-008 Port tgt_val  input  16  offered target pulse width, in clk cycles.
REQ-009 Port tgt_ready  output  1  target can be accepted this cycle.
REQ-010 Port servo_set_val  output  16  current commanded pulse width, fed to the downstream servo PWM stage.
REQ-011 Port frame_tick  output  1  one-cycle pulse per frame boundary.
REQ-012 Port at_target  output  1  servo_set_val equals active target.

Function
REQ-013 Frame counter (16 bit): counts up by 1 while ramp_enabled is high; when count >= frame_len, it wraps to 0 on the next edge and frame_tick is high for the following cycle (registered, exactly one cycle).
REQ-014 frame_len = 0 gives frame_tick high every cycle; lowering frame_len below the current count forces a wrap on the next edge (no 65536-cycle runaway).
REQ-015 tgt_ready = ramp_enabled AND pending-slot empty; transfer occurs when tgt_valid and tgt_ready are both high at a clock edge.
REQ-016 Accepted tgt_val is stored in a one-entry pending register, and the pending-full flag is set.
REQ-017 On the edge that raises frame_tick: step servo_set_val toward the active target (pre-transfer value), then copy pending into active target and clear pending-full, all on that one edge.
REQ-018 An acceptance on the same edge as a frame_tick transfer fills the pending slot; that value applies at the next frame, not the current one.
REQ-019 Step rule: pos < tgt -> pos = min(pos + step_val, tgt); pos > tgt -> pos = max(pos - step_val, tgt); arithmetic is 17-bit, so there is no wrap past 16'hFFFF or below 0.
REQ-020 step_val = 0 sets pos = tgt in one frame.
REQ-021 servo_set_val changes only on frame_tick edges, never mid-frame.
REQ-022 FSM IDLE: pos == tgt, at_target = 1.
REQ-023 FSM RAMP: pos != tgt, at_target = 0.
REQ-024 FSM transitions: IDLE->RAMP when a transfer makes tgt != pos; RAMP->IDLE on the frame where pos reaches tgt; at_target is registered, consistent with pos/tgt.
REQ-025 ramp_enabled low (synchronous): frame counter forced to 0; no frame_tick; tgt_ready = 0; pos, active target, pending slot and FSM state are held.
REQ-026 ramp_enabled rising: counting restarts from 0; the first frame_tick follows frame_len+1 cycles later.

Reset
REQ-027 rst_n low asynchronously sets: frame counter 0; frame_tick 0; servo_set_val = INIT_POS; active target = INIT_POS; pending empty; FSM IDLE; at_target 1.
REQ-028 tgt_ready is 0 while rst_n is low.
REQ-029 Reset mid-ramp discards the pending and active targets; the first clock edge after release resumes normal operation.

Verification
REQ-030 frame_len=9, enabled: frame_tick high exactly 1 cycle in every 10; changing frame_len 9->3 while count=7 -> tick on the next edge.
REQ-031 INIT_POS=0, step=100, target 350 accepted -> servo_set_val 0,100,200,300,350 on successive ticks; at_target rises with 350.
REQ-032 pos=1000, target 40, step=255 -> 745,490,235,40 (no underflow); pos=16'hFFF0, target 16'hFFFF, step=200 -> 16'hFFFF.
REQ-033 Pending full: second tgt_valid sees tgt_ready=0 until the tick; a target accepted on the tick edge applies one frame later.
REQ-034 ramp_enabled dropped mid-ramp for 50 cycles -> no ticks and pos frozen; on re-enable, the next tick comes frame_len+1 cycles later.
REQ-035 rst_n asserted asynchronously mid-ramp (between clock edges) -> outputs immediately take the REQ-027 values.
